// File: rtl/arb_mux.sv
// ---------------------------------------------------------------------------
// arb_mux
//
// Registered N-input stream multiplexer with built-in arbitration. Several
// valid/ready producers share one valid/ready consumer. The winner is picked
// by fixed priority (lowest index) or round-robin. Once a multi-beat packet
// starts, the grant is locked to that channel until its last beat is
// accepted. The selected beat is registered, which gives one cycle of
// latency from acceptance to dout.
//
// Parameters
//   data_size : width of each data channel in bits
//   num_in    : number of input channels (2..16)
//   sel_width : channel index width, ceil(log2(num_in))
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   mode       : 0 = fixed priority, 1 = round-robin
//   din        : packed input data, channel i at [i*data_size +: data_size]
//   din_valid  : per-channel valid
//   din_last   : per-channel last-beat flag, sampled when the beat is accepted
//   din_ready  : per-channel ready, at most one bit high
//   dout       : registered output data
//   dout_sel   : index of the channel that produced dout
//   dout_last  : registered last flag of the accepted beat
//   dout_valid : output valid
//   dout_ready : downstream ready
// ---------------------------------------------------------------------------
module arb_mux #(
    parameter int data_size = 32,
    parameter int num_in    = 4,
    parameter int sel_width = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic [num_in*data_size-1:0] din,
    input  logic [num_in-1:0]           din_valid,
    input  logic [num_in-1:0]           din_last,
    output logic [num_in-1:0]           din_ready,
    output logic [data_size-1:0]        dout,
    output logic [sel_width-1:0]        dout_sel,
    output logic                        dout_last,
    output logic                        dout_valid,
    input  logic                        dout_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [sel_width-1:0]   r_lockCh;
    logic [sel_width-1:0]   w_lockChNext;
    logic [sel_width-1:0]   r_ptr;
    logic [sel_width-1:0]   w_ptrNext;
    logic [sel_width-1:0]   w_ptrAfterWinner;

    logic [num_in-1:0]      w_grant;
    logic [sel_width-1:0]   w_winner;
    logic                   w_found;

    logic [data_size-1:0]   w_selData;
    logic                   w_selLast;

    logic                   w_canAccept;
    logic                   w_load;

    logic [data_size-1:0]   r_dout;
    logic [sel_width-1:0]   r_doutSel;
    logic                   r_doutLast;
    logic                   r_doutValid;

    // The output slot can take a new beat when it is empty or is being
    // drained this cycle, so accept and drain can share one edge.
    assign w_canAccept = !r_doutValid || dout_ready;
    assign w_load      = w_canAccept && |(din_valid & w_grant);

    // din_ready follows the grant, never din_valid directly. It is forced
    // low during reset because an empty output slot would otherwise
    // advertise ready while the block is held in reset.
    assign din_ready = (w_canAccept && !rst) ? w_grant : '0;

    // Grant selection. A locked packet owns the grant even while its
    // channel is idle, so a stalled packet cannot be interleaved with
    // another channel. In IDLE the policy chooses among valid channels:
    // lowest index for fixed priority, or the first valid channel at or
    // after ptr (wrapping) for round-robin.
    always_comb begin
        int idx;
        w_grant  = '0;
        w_winner = '0;
        w_found  = 1'b0;
        idx      = 0;
        if (r_state == LOCKED) begin
            w_grant[r_lockCh] = 1'b1;
            w_winner          = r_lockCh;
            w_found           = 1'b1;
        end else if (!mode) begin
            for (int i = 0; i < num_in; i++) begin
                if (din_valid[i] && !w_found) begin
                    w_grant[i] = 1'b1;
                    w_winner   = sel_width'(i);
                    w_found    = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < num_in; k++) begin
                idx = int'(r_ptr) + k;
                if (idx >= num_in) begin
                    idx = idx - num_in;
                end
                if (din_valid[idx] && !w_found) begin
                    w_grant[idx] = 1'b1;
                    w_winner     = sel_width'(idx);
                    w_found      = 1'b1;
                end
            end
        end
    end

    // One-hot AND-OR data mux. Ungranted channels are masked out entirely,
    // so their data and last flags can never leak onto the output.
    always_comb begin
        w_selData = '0;
        w_selLast = 1'b0;
        for (int i = 0; i < num_in; i++) begin
            if (w_grant[i]) begin
                w_selData = w_selData | din[i*data_size +: data_size];
                w_selLast = w_selLast | din_last[i];
            end
        end
    end

    // Round-robin pointer value after the current winner finishes a packet.
    assign w_ptrAfterWinner = (int'(w_winner) == num_in - 1)
                              ? '0 : w_winner + sel_width'(1);

    // Lock state machine and round-robin pointer. The pointer only moves
    // on an accepted last beat, so fairness is counted per packet rather
    // than per beat. It is updated in fixed-priority mode too, so that a
    // later switch to round-robin starts from a sensible place.
    always_comb begin
        w_stateNext  = r_state;
        w_lockChNext = r_lockCh;
        w_ptrNext    = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    if (w_selLast) begin
                        w_ptrNext = w_ptrAfterWinner;
                    end else begin
                        w_stateNext  = LOCKED;
                        w_lockChNext = w_winner;
                    end
                end
            end
            LOCKED: begin
                if (w_load && w_selLast) begin
                    w_stateNext = IDLE;
                    w_ptrNext   = w_ptrAfterWinner;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register. Reset drops any lock and restarts arbitration at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lockCh <= '0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_lockCh <= w_lockChNext;
            r_ptr    <= w_ptrNext;
        end
    end

    // Output register. On a drain without a new load only the valid bit
    // falls; data, sel and last keep their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout      <= '0;
            r_doutSel   <= '0;
            r_doutLast  <= 1'b0;
            r_doutValid <= 1'b0;
        end else if (w_load) begin
            r_dout      <= w_selData;
            r_doutSel   <= w_winner;
            r_doutLast  <= w_selLast;
            r_doutValid <= 1'b1;
        end else if (r_doutValid && dout_ready) begin
            r_doutValid <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign dout_sel   = r_doutSel;
    assign dout_last  = r_doutLast;
    assign dout_valid = r_doutValid;

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised, registered N-input stream multiplexer with built-in arbitration. It replaces fixed 4:1 select-driven muxing wherever several producers share one consumer, for example the writeback and memory-request paths. Each input and the output use a valid/ready handshake. The block chooses the winning input by fixed or round-robin priority, holds the grant across multi-beat transfers until the last beat, and registers the selected data for one cycle of latency.

## Interface
- data_size, 32, width of each data channel in bits
- num_in, 4, number of input channels (2..16)
- sel_width, 2, index width; must equal ceil(log2(num_in))

- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- mode  input  1  arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin
- din  input  num_in*data_size  packed input data; channel i occupies bits [i*data_size +: data_size]
- din_valid  input  num_in  per-channel valid
- din_last  input  num_in  per-channel last-beat flag; it is sampled only when that channel's beat is accepted
- din_ready  output  num_in  per-channel ready; at most one bit is high in any cycle
- dout  output  data_size  registered output data
- dout_sel  output  sel_width  index of the channel that produced the current dout
- dout_last  output  1  registered copy of the accepted din_last
- dout_valid  output  1  output valid
- dout_ready  input  1  downstream ready

## Operation
- Output register:
  - It loads when `load = (!dout_valid || dout_ready) && |(din_valid & grant)`.
  - On load, dout, dout_sel and dout_last take the granted channel's values, and dout_valid goes to 1.
  - When dout_valid && dout_ready and there is no load, dout_valid goes to 0. dout, dout_sel and dout_last keep their values.
- Ready: din_ready[i] = grant[i] && (!dout_valid || dout_ready).
- The grant is combinational and one-hot or zero. It is computed from din_valid, mode, ptr and the lock state.
- Fixed priority (mode=0): the lowest-indexed valid channel wins. ptr is ignored but is still updated.
- Round-robin (mode=1):
  - Search starts at index ptr and wraps modulo num_in.
  - The first valid channel found wins.
  - After a beat from channel k is accepted, ptr = (k+1) mod num_in. When k = num_in-1, ptr wraps to 0.
- Lock state machine:
  - States: IDLE and LOCKED, with a register lock_ch of width sel_width.
  - IDLE: the arbiter picks a winner. If the accepted beat has din_last=0, go to LOCKED with lock_ch = winner. If it has din_last=1, stay in IDLE.
  - LOCKED: the grant is forced to lock_ch. Other valid channels are ignored even if they have higher priority. If the lock channel deasserts valid, the grant stays on it and no load occurs.
  - LOCKED exits to IDLE when a beat from lock_ch is accepted with din_last=1.
  - ptr updates only on an accepted last beat, so round-robin fairness is counted per packet.
- Changing mode takes effect at the next IDLE arbitration. It never breaks a lock.
- Data and last flags of channels without a grant never reach the output.

## Timing
- Latency: a beat accepted on edge n appears on dout with dout_valid=1 after edge n, and stays until the edge on which dout_ready=1.
- Throughput: one beat per cycle while dout_ready=1 and some granted channel is valid. Accept and drain happen in the same cycle.
- The grant and din_ready are combinational from the inputs and state, with no registered delay. din_ready must not depend combinationally on din_valid of the same channel except through arbitration.
- Reset (asynchronous, takes effect immediately):
  - dout=0, dout_sel=0, dout_last=0, dout_valid=0.
  - State=IDLE, lock_ch=0, ptr=0.
  - din_ready=0 while rst=1.
- Reset asserted mid-packet drops the lock and any pending output beat. After reset the first arbitration starts from ptr=0.
- When no channel is valid, no load occurs and ptr and the state hold.
- When dout_valid=1 and dout_ready=0, all din_ready are 0 and dout is held stable.

## Test plan
- Fixed priority, num_in=4, mode=0, din_valid=4'b1010, all last=1, dout_ready=1:
  - din_ready=4'b0010 each cycle.
  - dout_sel=1 every cycle; channel 3 is starved.
- Round-robin, mode=0→1 after reset, din_valid=4'b1111 held, all last=1:
  - dout_sel sequence is 0,1,2,3,0 on consecutive cycles.
  - ptr wraps 3→0.
- Packet lock, mode=1:
  - Channel 2 sends 3 beats (last=0,0,1) while channel 0 is valid throughout.
  - Required: dout_sel=2,2,2 and then 0. Channel 0 gets no ready during the packet.
  - ptr=3 after the packet.
- Backpressure: load 0xDEADBEEF from channel 1, then hold dout_ready=0 for 5 cycles.
  - dout=0xDEADBEEF and dout_valid=1 stay stable.
  - All din_ready=0 during the hold.
  - On release, the next beat loads on the same edge that the drain occurs.
- Reset mid-packet: assert rst while LOCKED on channel 3 with dout_valid=1.
  - Outputs read 0 immediately and dout_valid=0.
  - After release with din_valid=4'b1001 and mode=1, dout_sel=0 first.
- Idle gap: din_valid=0 for 3 cycles after a drain.
  - dout_valid falls to 0 one edge after the drain and stays 0.
  - ptr is unchanged.
